// File: rtl/random_check16_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_check16_if                                                        |
// | Stream and status bundle for the 16-bit LFSR stream checker.             |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface random_check16_if;
    logic        in_valid;
    logic [15:0] in_data;
    logic        clear;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [31:0] word_count;

    modport master (
        output in_valid, in_data, clear,
        input  locked, err_pulse, err_count, word_count
    );

    modport slave (
        input  in_valid, in_data, clear,
        output locked, err_pulse, err_count, word_count
    );
endinterface
`default_nettype wire

// File: rtl/random_check16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | random_check16                                                           |
// | Self-synchronising checker for the 16-bit LFSR random stream.            |
// | Optional macro RANDOM_CHECK_STATS_EN enables the word_count statistic.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module random_check16 #(
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned LOSS_CNT = 3
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    random_check16_if.slave   bus
);

    localparam logic [1:0] c_SEARCH = 2'd0;
    localparam logic [1:0] c_VERIFY = 2'd1;
    localparam logic [1:0] c_LOCKED = 2'd2;

    localparam logic [3:0] c_LOCK_CNT = 4'(LOCK_CNT);
    localparam logic [3:0] c_LOSS_CNT = 4'(LOSS_CNT);

    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    logic [1:0]  r_state;
    logic [15:0] r_pred;
    logic [3:0]  r_match_cnt;
    logic [3:0]  r_miss_cnt;
    logic        r_locked;
    logic        r_err_pulse;
    logic [15:0] r_err_count;

    logic [1:0]  w_state_nxt;
    logic [15:0] w_pred_nxt;
    logic [3:0]  w_match_nxt;
    logic [3:0]  w_miss_nxt;
    logic        w_word_ok;
    logic        w_data_nz;
    logic        w_err_hit;
    logic [3:0]  w_match_inc;
    logic [3:0]  w_miss_inc;

    assign w_word_ok   = (bus.in_data == r_pred);
    assign w_data_nz   = |bus.in_data;
    assign w_match_inc = r_match_cnt + 4'd1;
    assign w_miss_inc  = r_miss_cnt + 4'd1;
    assign w_err_hit   = bus.in_valid && (r_state == c_LOCKED) && !w_word_ok;

    always_comb begin
        w_state_nxt = r_state;
        w_pred_nxt  = r_pred;
        w_match_nxt = r_match_cnt;
        w_miss_nxt  = r_miss_cnt;
        if (bus.in_valid) begin
            case (r_state)
                c_SEARCH: begin
                    // All-zero is the LFSR lock-up state and can never be a valid seed
                    if (w_data_nz) begin
                        w_pred_nxt  = lfsr_step(bus.in_data);
                        w_match_nxt = 4'd0;
                        w_state_nxt = c_VERIFY;
                    end
                end
                c_VERIFY: begin
                    if (w_word_ok) begin
                        w_pred_nxt  = lfsr_step(bus.in_data);
                        w_match_nxt = w_match_inc;
                        if (w_match_inc == c_LOCK_CNT) begin
                            w_state_nxt = c_LOCKED;
                            w_miss_nxt  = 4'd0;
                        end
                    end else if (w_data_nz) begin
                        w_pred_nxt  = lfsr_step(bus.in_data);
                        w_match_nxt = 4'd0;
                    end else begin
                        w_match_nxt = 4'd0;
                        w_state_nxt = c_SEARCH;
                    end
                end
                c_LOCKED: begin
                    // Free-run from the prediction so a corrupted word cannot poison later checks
                    w_pred_nxt = lfsr_step(r_pred);
                    if (w_word_ok) begin
                        w_miss_nxt = 4'd0;
                    end else if (w_miss_inc == c_LOSS_CNT) begin
                        w_miss_nxt  = 4'd0;
                        w_match_nxt = 4'd0;
                        w_state_nxt = c_SEARCH;
                    end else begin
                        w_miss_nxt = w_miss_inc;
                    end
                end
                default: begin
                    w_state_nxt = c_SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_SEARCH;
            r_pred      <= 16'd0;
            r_match_cnt <= 4'd0;
            r_miss_cnt  <= 4'd0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_pred      <= w_pred_nxt;
            r_match_cnt <= w_match_nxt;
            r_miss_cnt  <= w_miss_nxt;
            r_locked    <= (w_state_nxt == c_LOCKED);
            r_err_pulse <= w_err_hit;
            if (bus.clear) begin
                r_err_count <= 16'd0;
            end else if (w_err_hit && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

    assign bus.locked    = r_locked;
    assign bus.err_pulse = r_err_pulse;
    assign bus.err_count = r_err_count;

`ifdef RANDOM_CHECK_STATS_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= 32'd0;
        end else if (bus.clear) begin
            r_word_count <= 32'd0;
        end else if (bus.in_valid && (r_state == c_LOCKED) && (r_word_count != 32'hFFFF_FFFF)) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign bus.word_count = r_word_count;
`else
    assign bus.word_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_random_check16.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_random_check16                                                        |
// | Table-driven directed bench for the LFSR stream checker.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_random_check16;

    logic clk;
    logic rst_n;

    random_check16_if bus ();

    random_check16 #(
        .LOCK_CNT (4),
        .LOSS_CNT (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [15:0] data;
        logic        clr;
        logic        exp_lock;
        logic        exp_pulse;
        logic [15:0] exp_err;
    } vec_t;

    vec_t        tbl[$];
    logic [15:0] s[0:24];
    int          n_vec;
    int          n_fail;

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic add(input logic v, input logic [15:0] d, input logic c,
                       input logic el, input logic ep, input logic [15:0] ee);
        vec_t r;
        r.valid = v; r.data = d; r.clr = c;
        r.exp_lock = el; r.exp_pulse = ep; r.exp_err = ee;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_step(input logic v, input logic [15:0] d, input logic c);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 16'h0000;
        bus.clear    = 1'b0;

        // Reference stream; the first entries are the hand-derived 007B sequence
        s[0] = 16'h007B; s[1] = 16'h00F6; s[2] = 16'h01EC; s[3] = 16'h03D8;
        s[4] = 16'h07B0; s[5] = 16'h0F61; s[6] = 16'h1EC3; s[7] = 16'h3D86;
        for (int i = 8; i < 25; i++) s[i] = lfsr_next(s[i-1]);

        // Acquire lock: 5th word completes the 4th match
        add(1, s[0], 0, 0, 0, 0);
        add(1, s[1], 0, 0, 0, 0);
        add(1, s[2], 0, 0, 0, 0);
        add(1, s[3], 0, 0, 0, 0);
        add(1, s[4], 0, 1, 0, 0);
        // Single bit error stays isolated; an idle cycle changes nothing
        add(1, s[5], 0, 1, 0, 0);
        add(1, s[6] ^ 16'h0001, 0, 1, 1, 1);
        add(1, s[7], 0, 1, 0, 1);
        add(0, 16'hDEAD, 0, 1, 0, 1);
        add(1, s[8], 0, 1, 0, 1);
        // Three consecutive garbage words lose lock; the last is still counted
        add(1, ~s[9],  0, 1, 1, 2);
        add(1, ~s[10], 0, 1, 1, 3);
        add(1, ~s[11], 0, 0, 1, 4);
        // Zeros ignored in SEARCH, zero in VERIFY drops back, nonzero resyncs
        add(1, 16'h0000, 0, 0, 0, 4);
        add(1, 16'h0000, 0, 0, 0, 4);
        add(1, s[0], 0, 0, 0, 4);
        add(1, s[1], 0, 0, 0, 4);
        add(1, 16'h0000, 0, 0, 0, 4);
        add(1, s[0], 0, 0, 0, 4);
        add(1, s[1], 0, 0, 0, 4);
        add(1, 16'h1234, 0, 0, 0, 4);
        add(1, s[0], 0, 0, 0, 4);
        add(1, s[1], 0, 0, 0, 4);
        add(1, s[2], 0, 0, 0, 4);
        add(1, s[3], 0, 0, 0, 4);
        add(1, s[4], 0, 1, 0, 4);
        // Clear wins over a simultaneous mismatch, pulse still fires
        add(1, ~s[5], 1, 1, 1, 0);
        add(1, s[6],  0, 1, 0, 0);

        #12;
        chk("reset_locked", {31'd0, bus.locked}, 32'd0);
        chk("reset_pulse",  {31'd0, bus.err_pulse}, 32'd0);
        chk("reset_errcnt", {16'd0, bus.err_count}, 32'd0);
        chk("reset_wordcnt", bus.word_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            drive_step(tbl[i].valid, tbl[i].data, tbl[i].clr);
            chk($sformatf("v%0d_locked", i), {31'd0, bus.locked},    {31'd0, tbl[i].exp_lock});
            chk($sformatf("v%0d_pulse", i),  {31'd0, bus.err_pulse}, {31'd0, tbl[i].exp_pulse});
            chk($sformatf("v%0d_errcnt", i), {16'd0, bus.err_count}, {16'd0, tbl[i].exp_err});
`ifndef RANDOM_CHECK_STATS_EN
            chk($sformatf("v%0d_wordcnt", i), bus.word_count, 32'd0);
`endif
        end

        // Statistics: clear, then ten locked words
        drive_step(1, s[7], 1);
        chk("stats_clear_wordcnt", bus.word_count, 32'd0);
        for (int i = 0; i < 10; i++) drive_step(1, s[8+i], 0);
        chk("stats_locked", {31'd0, bus.locked}, 32'd1);
        chk("stats_errcnt", {16'd0, bus.err_count}, 32'd0);
`ifdef RANDOM_CHECK_STATS_EN
        chk("stats_wordcnt", bus.word_count, 32'd10);
`else
        chk("stats_wordcnt", bus.word_count, 32'd0);
`endif
        // Put one error in so the async reset has something to wipe
        drive_step(1, ~s[18], 0);
        chk("pre_rst_errcnt", {16'd0, bus.err_count}, 32'd1);
        bus.in_valid = 1'b0;

        // Asynchronous reset between clock edges while locked
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_locked", {31'd0, bus.locked}, 32'd0);
        chk("async_rst_errcnt", {16'd0, bus.err_count}, 32'd0);
        chk("async_rst_wordcnt", bus.word_count, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Resumes in SEARCH: relock needs LOCK_CNT+1 words again
        for (int i = 0; i < 4; i++) drive_step(1, s[i], 0);
        chk("relock_before", {31'd0, bus.locked}, 32'd0);
        drive_step(1, s[4], 0);
        chk("relock_after", {31'd0, bus.locked}, 32'd1);
        drive_step(1, s[5], 0);
        chk("relock_pulse", {31'd0, bus.err_pulse}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
